// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces active-low buttons into levels and press/release pulses.
// Define KEY_REPEAT_EN to add per-key auto-repeat press pulses while a masked key is held.
module button_conditioner #(
    parameter int NUM_KEYS = 3,
    parameter int SW_W = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W = 20,
    parameter int REPEAT_CYCLES = 64,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK = NUM_KEYS'(3'b100)
) (
    input  logic                CLK,
    input  logic                Reset_n,
    input  logic [NUM_KEYS-1:0] Key_n,
    input  logic [SW_W-1:0]     Sw,
    output logic [NUM_KEYS-1:0] Key_level,
    output logic [NUM_KEYS-1:0] Key_press,
    output logic [NUM_KEYS-1:0] Key_release,
    output logic [SW_W-1:0]     Sw_sync
);
    typedef enum logic [1:0] {UP, WAIT_DN, DN, WAIT_UP} state_t;
    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || (CNT_W < 31 && (1 << CNT_W) <= DEBOUNCE_CYCLES) ||
        REPEAT_CYCLES < 1 || $bits(REPEAT_MASK) != NUM_KEYS) begin : g_bad_cfg
        $error("button_conditioner: invalid parameter combination");
    end

    logic [NUM_KEYS-1:0] key_sync_q [SYNC_STAGES];
    logic [NUM_KEYS-1:0] key_sync_d [SYNC_STAGES];
    logic [SW_W-1:0]     sw_sync_q  [SYNC_STAGES];
    logic [SW_W-1:0]     sw_sync_d  [SYNC_STAGES];
    state_t              state_q    [NUM_KEYS];
    state_t              state_d    [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q      [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d      [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_inc    [NUM_KEYS];
    logic [NUM_KEYS-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
    logic [NUM_KEYS-1:0] held, diff;
    logic [NUM_KEYS-1:0] synced;
`ifdef KEY_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0]    rpt_q      [NUM_KEYS];
    logic [RPT_W-1:0]    rpt_d      [NUM_KEYS];
`endif

    assign synced = key_sync_q[SYNC_STAGES-1];

    always_comb begin
        key_sync_d[0] = Key_n;
        sw_sync_d[0]  = Sw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            key_sync_d[s] = key_sync_q[s-1];
            sw_sync_d[s]  = sw_sync_q[s-1];
        end
    end

    // held: debounced level is pressed; diff: synced input disagrees with it
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = '0;
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            held[i]      = state_q[i] == DN || state_q[i] == WAIT_UP;
            diff[i]      = held[i] ? synced[i] : !synced[i];
            cnt_inc[i]   = &cnt_q[i] ? cnt_q[i] : cnt_q[i] + 1'b1;
            if (!diff[i]) begin
                state_d[i] = held[i] ? DN : UP;
            end else if (cnt_inc[i] >= DEB) begin
                state_d[i]   = held[i] ? UP : DN;
                level_d[i]   = !held[i];
                press_d[i]   = !held[i];
                release_d[i] = held[i];
            end else begin
                state_d[i] = held[i] ? WAIT_UP : WAIT_DN;
                cnt_d[i]   = cnt_inc[i];
            end
`ifdef KEY_REPEAT_EN
            rpt_d[i] = '0;
            if (REPEAT_MASK[i] && held[i] && state_d[i] != UP) begin
                rpt_d[i] = rpt_q[i] + 1'b1;
                if (rpt_q[i] == RPT_LAST) begin
                    rpt_d[i]   = '0;
                    press_d[i] = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                key_sync_q[s] <= '1;
                sw_sync_q[s]  <= '0;
            end
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= UP;
                cnt_q[i]   <= '0;
`ifdef KEY_REPEAT_EN
                rpt_q[i]   <= '0;
`endif
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            key_sync_q <= key_sync_d;
            sw_sync_q  <= sw_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
`ifdef KEY_REPEAT_EN
            rpt_q      <= rpt_d;
`endif
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
        end
    end

    assign Key_level   = level_q;
    assign Key_press   = press_q;
    assign Key_release = release_q;
    assign Sw_sync     = sw_sync_q[SYNC_STAGES-1];
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench; expected pulses are queued by cycle when stimulus is driven.
module tb_button_conditioner;
    localparam int LAT = 2 + 4 - 1;

    logic       CLK = 1'b0;
    logic       Reset_n = 1'b0;
    logic [2:0] Key_n = 3'b111;
    logic [7:0] Sw = 8'h3B;
    logic [2:0] Key_level, Key_press, Key_release;
    logic [7:0] Sw_sync;

    typedef struct {int cyc; logic [2:0] p; logic [2:0] r;} ev_t;
    ev_t        sb[$];
    int         cyc = 0, tests = 0, failed = 0;
    logic [2:0] exp_lvl = 3'b000, ep, er;

    button_conditioner #(
        .NUM_KEYS(3), .SW_W(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(20),
        .REPEAT_CYCLES(8), .REPEAT_MASK(3'b100)
    ) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Key_n(Key_n), .Sw(Sw),
        .Key_level(Key_level), .Key_press(Key_press), .Key_release(Key_release), .Sw_sync(Sw_sync)
    );

    always #10 CLK = ~CLK;

    task automatic step(input logic [2:0] kn, input logic rn, input logic [7:0] sw);
        @(negedge CLK);
        Key_n = kn;
        Reset_n = rn;
        Sw = sw;
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    function automatic void push(input int c, input logic [2:0] p, input logic [2:0] r);
        sb.push_back('{c, p, r});
    endfunction

    function automatic void pop_expect();
        ep = 3'b000;
        er = 3'b000;
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            ep = sb[0].p;
            er = sb[0].r;
            void'(sb.pop_front());
        end
        exp_lvl = (exp_lvl | ep) & ~er;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(3'b111, 1'b0, 8'h3B);
            pop_expect();
            tests++;
            if ({Key_level, Key_press, Key_release, Sw_sync} !== 17'h0) begin
                failed++;
                $display("FAIL reset_hold cyc=%0d lvl/press/rel/sw got %b/%b/%b/%h want 0/0/0/00", cyc, Key_level, Key_press, Key_release, Sw_sync);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(3'b111, 1'b1, 8'h3B);
            pop_expect();
            tests++;
            if ({Key_level, Key_press, Key_release} !== 9'h0 || Sw_sync !== (i == 0 ? 8'h00 : 8'h3B)) begin
                failed++;
                $display("FAIL reset_release cyc=%0d lvl/press/rel/sw got %b/%b/%b/%h want 0/0/0/%h", cyc, Key_level, Key_press, Key_release, Sw_sync, i == 0 ? 8'h00 : 8'h3B);
            end
        end
    endtask

    task automatic test_sw();
        for (int i = 0; i < 3; i++) begin
            step(3'b111, 1'b1, 8'hA5);
            tests++;
            if (Sw_sync !== (i == 0 ? 8'h3B : 8'hA5)) begin
                failed++;
                $display("FAIL sw_sync cyc=%0d got %h want %h", cyc, Sw_sync, i == 0 ? 8'h3B : 8'hA5);
            end
        end
    endtask

    task automatic test_clean_press();
        for (int i = 0; i < 24; i++) begin
            step(i < 12 ? 3'b011 : 3'b111, 1'b1, 8'hA5);
            if (i == 0) push(cyc + LAT, 3'b100, 3'b000);
            if (i == 12) push(cyc + LAT, 3'b000, 3'b100);
            pop_expect();
            tests++;
            if ({Key_level, Key_press, Key_release} !== {exp_lvl, ep, er}) begin
                failed++;
                $display("FAIL clean_press cyc=%0d lvl/press/rel got %b/%b/%b want %b/%b/%b", cyc, Key_level, Key_press, Key_release, exp_lvl, ep, er);
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 28; i++) begin
            step((i < 3 || (i >= 4 && i < 16)) ? 3'b101 : 3'b111, 1'b1, 8'hA5);
            if (i == 4) push(cyc + LAT, 3'b010, 3'b000);
            if (i == 16) push(cyc + LAT, 3'b000, 3'b010);
            pop_expect();
            tests++;
            if ({Key_level, Key_press, Key_release} !== {exp_lvl, ep, er}) begin
                failed++;
                $display("FAIL bounce cyc=%0d lvl/press/rel got %b/%b/%b want %b/%b/%b", cyc, Key_level, Key_press, Key_release, exp_lvl, ep, er);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 32; i++) begin
            step(i < 10 ? 3'b000 : (i == 20 || i == 21) ? 3'b110 : 3'b111, 1'b1, 8'hA5);
            if (i == 0) push(cyc + LAT, 3'b111, 3'b000);
            if (i == 10) push(cyc + LAT, 3'b000, 3'b111);
            pop_expect();
            tests++;
            if ({Key_level, Key_press, Key_release} !== {exp_lvl, ep, er}) begin
                failed++;
                $display("FAIL simultaneous cyc=%0d lvl/press/rel got %b/%b/%b want %b/%b/%b", cyc, Key_level, Key_press, Key_release, exp_lvl, ep, er);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 26; i++) begin
            step(i < 16 ? 3'b011 : 3'b111, !(i >= 2 && i < 6), 8'hA5);
            if (i >= 2 && i < 6) exp_lvl = 3'b000;
            if (i == 6) push(cyc + LAT, 3'b100, 3'b000);
            if (i == 16) push(cyc + LAT, 3'b000, 3'b100);
            pop_expect();
            tests++;
            if ({Key_level, Key_press, Key_release} !== {exp_lvl, ep, er}) begin
                failed++;
                $display("FAIL mid_reset cyc=%0d lvl/press/rel got %b/%b/%b want %b/%b/%b", cyc, Key_level, Key_press, Key_release, exp_lvl, ep, er);
            end
        end
    endtask

    // keys 0 and 2 held together for 30 samples; only key 2 is repeat-enabled
    task automatic test_hold();
        for (int i = 0; i < 44; i++) begin
            step(i < 30 ? 3'b010 : 3'b111, 1'b1, 8'hA5);
            if (i == 0) begin
                push(cyc + LAT, 3'b101, 3'b000);
`ifdef KEY_REPEAT_EN
                for (int t = 8; t < 30; t += 8) push(cyc + LAT + t, 3'b100, 3'b000);
`endif
            end
            if (i == 30) push(cyc + LAT, 3'b000, 3'b101);
            pop_expect();
            tests++;
            if ({Key_level, Key_press, Key_release} !== {exp_lvl, ep, er}) begin
                failed++;
                $display("FAIL hold cyc=%0d lvl/press/rel got %b/%b/%b want %b/%b/%b", cyc, Key_level, Key_press, Key_release, exp_lvl, ep, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_mid_reset();
        test_hold();
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
